// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the dual-clock FIFO pointer blocks.
//   PTR_MAX_W    : widest pointer supported (ADDR_SIZE 16 -> 17 bits).
//   fifo_depth() : DEPTH = 2**ADDR_SIZE, usable in localparams.
//   bin2gray()   : binary -> Gray, on a zero-extended PTR_MAX_W vector.
//   gray2bin()   : Gray -> binary, on a zero-extended PTR_MAX_W vector.
//   fifo_flags_t : status flags shared by the write- and read-side blocks.
package fifo_pkg;

  localparam int PTR_MAX_W = 17;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic overflow;
  } fifo_flags_t;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  // Callers zero-extend their ADDR_SIZE+1 pointer into PTR_MAX_W bits and
  // cast the result back. The extra zero bits above the real MSB do not
  // change either conversion.
  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_full_level_if.sv
// wptr_full_level_if
// Write-side bundle of the dual-clock FIFO write-pointer block.
//   w_inc, af_thresh, ovf_clr : from the write client
//   rptr_gray                 : Gray read pointer from the read domain
//   waddr                     : RAM write address
//   w_ptr                     : Gray write pointer to the read domain
//   w_full, w_almost_full, w_level, w_overflow : write-side status
//
// Handshake: w_inc is the valid and ~w_full is the ready. A word is
// transferred on a w_clk rising edge where both are high. w_inc may be
// raised regardless of w_full. When w_full is high the word is dropped and
// w_overflow latches. The RAM writes at waddr in that same cycle.
interface wptr_full_level_if #(
  parameter int ADDR_SIZE = 9
);

  logic                 w_inc;
  logic [ADDR_SIZE:0]   rptr_gray;
  logic [ADDR_SIZE:0]   af_thresh;
  logic                 ovf_clr;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   w_ptr;
  logic                 w_full;
  logic                 w_almost_full;
  logic [ADDR_SIZE:0]   w_level;
  logic                 w_overflow;

  modport master (
    output w_inc, rptr_gray, af_thresh, ovf_clr,
    input  waddr, w_ptr, w_full, w_almost_full, w_level, w_overflow
  );

  modport slave (
    input  w_inc, rptr_gray, af_thresh, ovf_clr,
    output waddr, w_ptr, w_full, w_almost_full, w_level, w_overflow
  );

endinterface

// File: rtl/ptr_sync.sv
// ptr_sync
// Multi-flop synchroniser for a Gray pointer crossing clock domains. It is
// used in both the write and the read domain.
//   clk, rst_n : destination clock and its async active-low reset
//   d          : Gray pointer from the other domain
//   q          : pointer after STAGES flops
module ptr_sync #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/wptr_full_level.sv
// wptr_full_level
// Write-domain pointer and flag generator for the dual-clock FIFO.
//   w_clk, wrst_n : write clock and its async active-low reset
//   bus (slave)   : w_inc, rptr_gray, af_thresh, ovf_clr in;
//                   waddr, w_ptr, w_full, w_almost_full, w_level,
//                   w_overflow out
// The read pointer is synchronised into w_clk here. Level and flags are
// computed from the next write pointer, so a write shows in the flags on
// the following cycle. A read only shows SYNC_STAGES+1 edges later, which
// makes full release and level decrease pessimistic.
module wptr_full_level
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE   = 9,
  parameter int SYNC_STAGES = 2
) (
  input logic               w_clk,
  input logic               wrst_n,
  wptr_full_level_if.slave  bus
);

  localparam int PTR_W = ADDR_SIZE + 1;

  logic [PTR_W-1:0] wbin_q;
  logic [PTR_W-1:0] wgray_q;
  logic [PTR_W-1:0] level_q;
  fifo_flags_t      flags_q;

  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rq_gray;
  logic [PTR_W-1:0] rq_bin;
  logic [PTR_W-1:0] level_next;
  logic             accept;
  logic             full_next;
  logic             af_next;

  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (w_clk),
    .rst_n (wrst_n),
    .d     (bus.rptr_gray),
    .q     (rq_gray)
  );

  always_comb begin
    accept     = bus.w_inc & ~flags_q.full;
    wbin_next  = wbin_q + PTR_W'(accept);
    wgray_next = PTR_W'(bin2gray(PTR_MAX_W'(wbin_next)));
    rq_bin     = PTR_W'(gray2bin(PTR_MAX_W'(rq_gray)));
    // The pointers differ by at most DEPTH. The modular difference is
    // therefore the true occupancy.
    level_next = wbin_next - rq_bin;
    // Full means exactly one lap ahead. In Gray code that is the read
    // pointer with its two top bits inverted.
    full_next  = (wgray_next ==
                  {~rq_gray[ADDR_SIZE:ADDR_SIZE-1], rq_gray[ADDR_SIZE-2:0]});
    af_next    = (level_next >= bus.af_thresh);
  end

  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      flags_q <= '0;
    end else begin
      wbin_q              <= wbin_next;
      wgray_q             <= wgray_next;
      level_q             <= level_next;
      flags_q.full        <= full_next;
      flags_q.almost_full <= af_next;
      // A fresh overflow takes priority over a clear in the same cycle.
      if (bus.w_inc && flags_q.full) begin
        flags_q.overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        flags_q.overflow <= 1'b0;
      end
    end
  end

  assign bus.waddr         = wbin_q[ADDR_SIZE-1:0];
  assign bus.w_ptr         = wgray_q;
  assign bus.w_level       = level_q;
  assign bus.w_full        = flags_q.full;
  assign bus.w_almost_full = flags_q.almost_full;
  assign bus.w_overflow    = flags_q.overflow;

endmodule

// File: tb/tb_wptr_full_level.sv
// tb_wptr_full_level
// Bench for wptr_full_level with ADDR_SIZE=4 and SYNC_STAGES=2.
// Each driven cycle pushes the model's expected outputs into exp_q. The
// entry is popped and compared one step after the rising edge.
module tb_wptr_full_level;

  localparam int ADDR_SIZE = 4;
  localparam int SYNC      = 2;
  localparam int DEPTH     = fifo_pkg::fifo_depth(ADDR_SIZE);
  localparam int EW        = 17;

  logic clk;
  logic wrst_n;

  wptr_full_level_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

  wptr_full_level #(
    .ADDR_SIZE   (ADDR_SIZE),
    .SYNC_STAGES (SYNC)
  ) dut (
    .w_clk  (clk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int   wcnt;
  int   rcnt;
  int   rsync [SYNC];
  logic m_full;
  logic m_ovf;
  int   thresh;
  int   wraps;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wcnt   = 0;
    rcnt   = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    for (int i = 0; i < SYNC; i++) rsync[i] = 0;
    exp_q.delete();
  endtask

  // Entered and left at a falling edge. Mid-cycle reset, checked before
  // any clock edge arrives.
  task automatic do_reset();
    #2;
    wrst_n        = 1'b0;
    bus.w_inc     = 1'b0;
    bus.ovf_clr   = 1'b0;
    bus.rptr_gray = '0;
    bus.af_thresh = 5'(thresh);
    #1;
    check("rst_waddr", 32'(bus.waddr), 0);
    check("rst_wptr", 32'(bus.w_ptr), 0);
    check("rst_full", 32'(bus.w_full), 0);
    check("rst_af", 32'(bus.w_almost_full), 0);
    check("rst_level", 32'(bus.w_level), 0);
    check("rst_ovf", 32'(bus.w_overflow), 0);
    model_reset();
    @(negedge clk);
    wrst_n = 1'b1;
  endtask

  // Driver plus model for one cycle. Entered and left at a falling edge.
  task automatic step(input logic inc, input logic rd, input logic clr);
    logic          acc;
    int            wn;
    int            lvl;
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    if (rd && rcnt < wcnt) rcnt++;
    bus.w_inc     = inc;
    bus.ovf_clr   = clr;
    bus.rptr_gray = gray5(rcnt);
    bus.af_thresh = 5'(thresh);
    acc = inc && !m_full;
    wn  = wcnt + int'(acc);
    lvl = wn - rsync[SYNC-1];
    e[16:13] = 4'(wn % DEPTH);
    e[12:8]  = gray5(wn);
    e[7]     = (lvl == DEPTH);
    e[6]     = (lvl >= thresh);
    e[5:1]   = 5'(lvl);
    e[0]     = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    exp_q.push_back(e);
    wcnt   = wn;
    m_full = e[7];
    m_ovf  = e[0];
    for (int i = SYNC - 1; i > 0; i--) rsync[i] = rsync[i-1];
    rsync[0] = rcnt;
    @(posedge clk);
    #1;
    got = {bus.waddr, bus.w_ptr, bus.w_full, bus.w_almost_full,
           bus.w_level, bus.w_overflow};
    e = exp_q.pop_front();
    check("waddr", 32'(got[16:13]), 32'(e[16:13]));
    check("w_ptr", 32'(got[12:8]), 32'(e[12:8]));
    check("w_full", 32'(got[7]), 32'(e[7]));
    check("w_af", 32'(got[6]), 32'(e[6]));
    check("w_level", 32'(got[5:1]), 32'(e[5:1]));
    check("w_ovf", 32'(got[0]), 32'(e[0]));
    check("full_vs_level", 32'(bus.w_full), 32'(bus.w_level == 5'(DEPTH)));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cycles;
    int prev_waddr;
    thresh        = 12;
    wrst_n        = 1'b0;
    bus.w_inc     = 1'b0;
    bus.ovf_clr   = 1'b0;
    bus.rptr_gray = '0;
    bus.af_thresh = 5'(thresh);
    model_reset();
    @(negedge clk);
    do_reset();

    // A few writes, then a mid-stream reset, then one idle cycle.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    check("post_rst_wptr", 32'(bus.w_ptr), 0);

    // Fill to full. Almost-full rises after the 12th write.
    repeat (11) step(1'b1, 1'b0, 1'b0);
    check("af_before_12", 32'(bus.w_almost_full), 0);
    step(1'b1, 1'b0, 1'b0);
    check("af_after_12", 32'(bus.w_almost_full), 1);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    check("fill_level", 32'(bus.w_level), 16);
    check("fill_full", 32'(bus.w_full), 1);
    check("fill_wptr", 32'(bus.w_ptr), 32'h18);

    // Write into a full FIFO, then test set-beats-clear and a lone clear.
    step(1'b1, 1'b0, 1'b0);
    check("ovf_wptr_hold", 32'(bus.w_ptr), 32'h18);
    check("ovf_set", 32'(bus.w_overflow), 1);
    step(1'b1, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(bus.w_overflow), 1);
    step(1'b0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(bus.w_overflow), 0);

    // Almost-full falls SYNC+1 edges after the read pointer moves 0 -> 1.
    do_reset();
    repeat (12) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("af_hold_1", 32'(bus.w_almost_full), 1);
    step(1'b0, 1'b0, 1'b0);
    check("af_hold_2", 32'(bus.w_almost_full), 1);
    step(1'b0, 1'b0, 1'b0);
    check("af_fall", 32'(bus.w_almost_full), 0);
    check("af_fall_level", 32'(bus.w_level), 11);

    // Wrap-around with random interleaved writes and read advances.
    do_reset();
    cycles     = 0;
    wraps      = 0;
    prev_waddr = 0;
    while (wcnt < 40 && cycles < 600) begin
      step(1'(($urandom_range(0, 3)) != 0), 1'($urandom_range(0, 1)), 1'b0);
      if (prev_waddr == DEPTH - 1 && int'(bus.waddr) == 0) wraps++;
      prev_waddr = int'(bus.waddr);
      cycles++;
    end
    check("wrap_writes", 32'(wcnt), 40);
    check("wrap_count", 32'(wraps), 2);

    // Threshold 0: held low in reset, asserted on the first clock.
    thresh = 0;
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    check("af_thr0", 32'(bus.w_almost_full), 1);

    // Threshold above DEPTH: never asserted, even when full.
    thresh = DEPTH + 1;
    do_reset();
    repeat (DEPTH) step(1'b1, 1'b0, 1'b0);
    check("af_thr17_full", 32'(bus.w_full), 1);
    check("af_thr17", 32'(bus.w_almost_full), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wptr_full_level.md
# wptr_full_level

Write-domain pointer and flag generator for the dual-clock FIFO, parametrised in depth and synchroniser length. It produces the Gray write pointer and binary RAM write address, and synchronises the read pointer into `w_clk` internally. It adds a fill level, a programmable almost-full flag and a sticky overflow flag to the full flag. It sits between the write-side client, the dual-port RAM write port and the read-domain pointer block.

## Interface
Parameters:
- `ADDR_SIZE`, default 9: RAM address width; FIFO depth `DEPTH = 2**ADDR_SIZE`; legal range 2..16.
- `SYNC_STAGES`, default 2: flop stages in the read-pointer synchroniser; legal range 2..4.

Ports (reset wrst_n, asynchronous, active-low; clock w_clk):
- `w_clk` in, 1: write-domain clock.
- `wrst_n` in, 1: asynchronous active-low reset; deassertion is synchronous to `w_clk` upstream.
- `w_inc` in, 1: write request from the client.
- `rptr_gray` in, ADDR_SIZE+1: Gray read pointer, registered in the read domain and asynchronous to `w_clk`.
- `af_thresh` in, ADDR_SIZE+1: almost-full threshold in words; quasi-static.
- `ovf_clr` in, 1: clears `w_overflow`.
- `waddr` out, ADDR_SIZE: RAM write address, equal to `wbin[ADDR_SIZE-1:0]`.
- `w_ptr` out, ADDR_SIZE+1: registered Gray write pointer, sent to the read domain.
- `w_full` out, 1: registered full flag.
- `w_almost_full` out, 1: registered; asserted when level ≥ `af_thresh`.
- `w_level` out, ADDR_SIZE+1: registered occupancy as seen from the write side, 0..DEPTH.
- `w_overflow` out, 1: sticky; set by a write attempted while full.

## Operation
- A write is accepted when `accept = w_inc & ~w_full`. A write attempted while full is dropped: pointers do not move and no RAM write occurs.
- Pointer update:
  - `wbin_next = wbin + accept`, computed modulo 2^(ADDR_SIZE+1).
  - `wgray_next = (wbin_next >> 1) ^ wbin_next`.
  - `wbin` and `w_ptr` both register on every clock.
- Read-pointer synchronisation:
  - `rptr_gray` passes through `SYNC_STAGES` flops, giving `rq_gray`.
  - `rq_gray` is converted combinationally to binary `rq_bin`.
- Flag computation:
  - `level_next = wbin_next - rq_bin`, modulo 2^(ADDR_SIZE+1); the result is always ≤ DEPTH.
  - `full_next = (wgray_next == {~rq_gray[A:A-1], rq_gray[A-2:0]})`, where `A = ADDR_SIZE`. This must agree with `level_next == DEPTH`; the bench asserts the equivalence.
  - `af_next = (level_next >= af_thresh)`. A threshold of 0 holds the flag asserted; a threshold greater than DEPTH holds it deasserted.
  - `w_level`, `w_full` and `w_almost_full` register `level_next`, `full_next` and `af_next` respectively.
- Overflow:
  - Set condition: `w_inc & w_full`.
  - Clear condition: `ovf_clr`.
  - If both occur in the same cycle, set wins.
- Wrap-around: `wbin` rolls from 2·DEPTH−1 to 0. `waddr` rolls from DEPTH−1 to 0 every DEPTH writes. The Gray MSB toggles on each `waddr` wrap.

## Timing
- Reset values:
  - `wbin`, `w_ptr` and `waddr` are 0.
  - All synchroniser flops are 0.
  - `w_level`, `w_full`, `w_almost_full` and `w_overflow` are 0, except `w_almost_full` resets to 0 even when `af_thresh` = 0. It asserts on the first clock after reset.
- A reset asserted mid-operation clears all state immediately, without waiting for a clock. Resetting the read side is a system-level concern.
- Write-to-flag latency: a write accepted in cycle N is reflected in `w_level`, `w_full` and `w_almost_full` at the start of cycle N+1. The FIFO therefore never accepts DEPTH+1 words.
- Read-to-flag latency: a change on `rptr_gray` first affects the flags after `SYNC_STAGES`+1 `w_clk` edges. Full deassertion and level decrease are pessimistic; they are never early.
- `waddr` updates together with `w_ptr`. The RAM writes at `waddr` in the cycle `accept` is high.
- A simultaneous write and read-pointer advance in the same cycle nets out: the level stays unchanged once the read update lands.
- `w_overflow` asserts the cycle after the offending `w_inc` and holds until `ovf_clr` is seen at a clock edge.

## Structure
- Shared package `fifo_pkg`:
  - functions `bin2gray` and `gray2bin`, parametrised via `ADDR_SIZE+1`-bit arguments;
  - a localparam helper for DEPTH;
  - the `fifo_flags_t` struct {full, almost_full, overflow}, for reuse by the read-side successor.
- One sub-module, `ptr_sync`: a `SYNC_STAGES`-deep, (ADDR_SIZE+1)-bit synchroniser with asynchronous active-low reset. The same module is reused in the read domain.
- Everything else lives in `wptr_full_level`.

## Test plan
1. **Reset:** ADDR_SIZE=4, hold `rptr_gray`=0, pulse `wrst_n` low mid-stream → all outputs 0 immediately; `w_ptr`=0 and `waddr`=0 after release.
2. **Fill to full:** with `rptr_gray`=0, write 16 times →
   - `w_level` counts 1..16;
   - `w_full`=1 the cycle after write 16, with `w_ptr`=5'b11000;
   - a 17th `w_inc` leaves the pointers unchanged and sets `w_overflow`=1.
3. **Almost-full threshold:** `af_thresh`=12 →
   - `w_almost_full` rises the cycle after the 12th write;
   - it falls SYNC_STAGES+1 cycles after `rptr_gray` advances to Gray(1) with level 12→11.
4. **Wrap-around:** interleave writes and read-pointer advances for 40 writes →
   - `waddr` wraps 15→0 twice;
   - `w_ptr` is always Gray of the write count mod 32;
   - `w_full` equals (`w_level`==16) on every cycle.
5. **Overflow clear:** assert `ovf_clr` and a full-state `w_inc` in the same cycle → `w_overflow` stays 1. `ovf_clr` alone → 0 next cycle.
6. **Threshold extremes:**
   - `af_thresh`=0 → `w_almost_full`=1 from the first clock after reset;
   - `af_thresh`=17 → never asserted, even when full.
